// File: rtl/uart_tx_fifo_serializer.sv
// Byte FIFO feeding an 8N1 UART transmitter, LSB first, with status/debug outputs.
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx_fifo_serializer #(
    parameter int unsigned CLKS_PER_BIT    = 868,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       S_AXI_ACLK,
    input  logic                       S_AXI_ARESET,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    output logic                       fifo_full,
    output logic                       fifo_empty,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
    output logic                       o_overflow,
    output logic                       uart_txd,
    output logic                       o_tx_active,
    output logic                       o_tx_done,
    output logic [2:0]                 o_SM_Main
);

    localparam int unsigned DEPTH    = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned CW       = FIFO_DEPTH_LOG2 + 1;
    localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        CLEANUP = 3'd5
    } sm_e;

    sm_e                        state;
    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [15:0]                clk_cnt;
    logic [2:0]                 bit_idx;
    logic [7:0]                 shift;
    logic                       push;
    logic                       pop;
    logic                       bit_end;

    assign fifo_full  = (fifo_count == CW'(DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign push       = wr_en && !fifo_full;
    assign pop        = (state == IDLE) && !fifo_empty;
    assign bit_end    = (clk_cnt == CNT_LAST);
    assign o_SM_Main  = state;

    // Storage needs no reset; occupancy is tracked by fifo_count alone.
    always_ff @(posedge S_AXI_ACLK) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && fifo_full) o_overflow <= 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Transmit state machine; the line value for each state is loaded on entry.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state       <= IDLE;
            uart_txd    <= 1'b1;
            o_tx_active <= 1'b0;
            o_tx_done   <= 1'b0;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
        end else begin
            o_tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    uart_txd    <= 1'b1;
                    o_tx_active <= 1'b0;
                    clk_cnt     <= '0;
                    bit_idx     <= '0;
                    if (pop) begin
                        shift       <= mem[rd_ptr];
                        uart_txd    <= 1'b0;
                        o_tx_active <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt  <= '0;
                        bit_idx  <= '0;
                        uart_txd <= shift[0];
                        state    <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            uart_txd <= ^shift;
                            state    <= PARITY;
`else
                            uart_txd <= 1'b1;
                            state    <= STOP;
`endif
                        end else begin
                            bit_idx  <= bit_idx + 3'd1;
                            uart_txd <= shift[bit_idx + 3'd1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        clk_cnt  <= '0;
                        uart_txd <= 1'b1;
                        state    <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        clk_cnt     <= '0;
                        o_tx_active <= 1'b0;
                        o_tx_done   <= 1'b1;
                        state       <= CLEANUP;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                CLEANUP: begin
                    uart_txd <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    uart_txd    <= 1'b1;
                    o_tx_active <= 1'b0;
                    clk_cnt     <= '0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
